// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and encodings for the data-memory arbiter
package mem_ctrl_pkg;

    localparam int CMD_ADDR_W = 4;
    localparam int CMD_DATA_W = 16;

    localparam logic [1:0] LS_NOP   = 2'b00;
    localparam logic [1:0] LS_STORE = 2'b01;
    localparam logic [1:0] LS_LOAD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  port;
        logic [1:0]            l_s;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Only store and load reach the memory; every other code is a NOP.
    function automatic logic [1:0] mem_op(input logic [1:0] l_s);
        return (l_s == LS_STORE || l_s == LS_LOAD) ? l_s : LS_NOP;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_arb2.sv
// rtl/mem_access_arbiter_rr_arb2.sv - two-request round-robin picker
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] grant
);

    // On contention the port that did not win last time goes first.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares the single-port data memory between fetch and load/store
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_l_s,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_l_s,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic [1:0]        mem_l_s,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              accept;
    logic              resp_active;

    rr_arb2 u_rr_arb2 (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (grant)
    );

    // A new command can be taken whenever the memory is not being driven.
    assign accept     = !rst && (state_q != ISSUE) && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];

    always_comb begin
        state_d      = IDLE;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        rdata_d      = rdata_q;
        if (state_q == ISSUE) begin
            state_d = RESP;
            rdata_d = (cmd_q.l_s == LS_LOAD) ? mem_rdata : '0;
        end
        if (accept) begin
            state_d      = ISSUE;
            last_grant_d = grant[1];
            cmd_d.port   = grant[1];
            cmd_d.l_s    = grant[1] ? req1_l_s   : req0_l_s;
            cmd_d.addr   = grant[1] ? req1_addr  : req0_addr;
            cmd_d.wdata  = grant[1] ? req1_wdata : req0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cmd_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            rdata_q      <= rdata_d;
        end
    end

    // Reset blanks the access strobe immediately so an in-flight store never lands.
    assign mem_l_s   = (state_q == ISSUE && !rst) ? mem_op(cmd_q.l_s) : LS_NOP;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    assign resp_active = (state_q == RESP) && !rst;
    assign resp0_valid = resp_active && !cmd_q.port;
    assign resp1_valid = resp_active && cmd_q.port;
    assign resp0_rdata = resp0_valid ? rdata_q : '0;
    assign resp1_rdata = resp1_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - randomized scoreboard bench for mem_access_arbiter
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]  req0_l_s = 2'b00, req1_l_s = 2'b00;
    logic [3:0]  req0_addr = 4'd0, req1_addr = 4'd0;
    logic [15:0] req0_wdata = 16'd0, req1_wdata = 16'd0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [15:0] resp0_rdata, resp1_rdata;
    logic [1:0]  mem_l_s;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        req0_ready_f, req1_ready_f, resp0_valid_f, resp1_valid_f;
    logic [15:0] resp0_rdata_f, resp1_rdata_f;
    logic [1:0]  mem_l_s_f;
    logic [3:0]  mem_addr_f;
    logic [15:0] mem_wdata_f, mem_rdata_f;

    logic [15:0] mem  [16];
    logic [15:0] memf [16];
    logic [15:0] ref_mem [16];

    typedef struct { int due; logic [1:0] ls; logic [3:0] addr; logic [15:0] wdata; } acc_t;
    typedef struct { int due; logic port; logic [15:0] rdata; } resp_t;
    acc_t  accq[$];
    resp_t respq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc = -10;
    logic lg = 1'b1;
    logic fixed_phase = 1'b0;
    int fixed_grants = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_l_s(req0_l_s),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_l_s(req1_l_s),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .mem_l_s(mem_l_s), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_access_arbiter #(.FIXED_PRIO(1)) dut_f (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready_f), .req0_l_s(req0_l_s),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid_f), .resp0_rdata(resp0_rdata_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready_f), .req1_l_s(req1_l_s),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid_f), .resp1_rdata(resp1_rdata_f),
        .mem_l_s(mem_l_s_f), .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f)
    );

    assign mem_rdata   = mem[mem_addr];
    assign mem_rdata_f = memf[mem_addr_f];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= 16'd0;
                memf[i] <= 16'd0;
            end
        end else begin
            if (mem_l_s == 2'b01)   mem[mem_addr]    <= mem_wdata;
            if (mem_l_s_f == 2'b01) memf[mem_addr_f] <= mem_wdata_f;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always begin
        @(negedge clk);
        #1;
        while (accq.size() > 0 && accq[0].due < cyc) begin
            check("mem_access_missed", 64'(accq[0].due), 64'(cyc));
            void'(accq.pop_front());
        end
        if (accq.size() > 0 && accq[0].due == cyc) begin
            acc_t a;
            a = accq.pop_front();
            check("mem_access", 64'({mem_l_s, mem_addr, mem_wdata}), 64'({a.ls, a.addr, a.wdata}));
        end else begin
            check("mem_idle", 64'(mem_l_s), 64'(2'b00));
        end
        while (respq.size() > 0 && respq[0].due < cyc) begin
            check("resp_missed", 64'(respq[0].due), 64'(cyc));
            void'(respq.pop_front());
        end
        if (respq.size() > 0 && respq[0].due == cyc) begin
            resp_t r;
            r = respq.pop_front();
            check("resp", 64'({resp0_valid, resp1_valid, resp0_rdata, resp1_rdata}),
                  64'({!r.port, r.port, r.port ? 16'd0 : r.rdata, r.port ? r.rdata : 16'd0}));
        end else begin
            check("resp_idle", 64'({resp0_valid, resp1_valid}), 64'(2'b00));
        end
    end

    // Reference model: one accept at most every other cycle, alternating winner on contention.
    task automatic judge();
        logic [1:0]  exp_rdy;
        logic        g;
        logic [1:0]  ls;
        logic [3:0]  a;
        logic [15:0] d, rd;
        exp_rdy = 2'b00;
        if (!rst && (cyc - last_acc) != 1) begin
            if (req0_valid && req1_valid) exp_rdy = lg ? 2'b01 : 2'b10;
            else exp_rdy = {req1_valid, req0_valid};
        end
        check("ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
        if (fixed_phase) begin
            check("fixed_ready1", 64'(req1_ready_f), 64'(1'b0));
            if (req0_ready_f) fixed_grants++;
        end
        if (exp_rdy != 2'b00) begin
            g = exp_rdy[1];
            lg = g;
            last_acc = cyc;
            ls = g ? req1_l_s : req0_l_s;
            a  = g ? req1_addr : req0_addr;
            d  = g ? req1_wdata : req0_wdata;
            rd = 16'd0;
            if (ls == 2'b01) ref_mem[a] = d;
            else if (ls == 2'b10) rd = ref_mem[a];
            accq.push_back('{cyc + 1, (ls == 2'b01 || ls == 2'b10) ? ls : 2'b00, a, d});
            respq.push_back('{cyc + 2, g, rd});
        end
    endtask

    task automatic step(input logic v0, input logic [1:0] l0, input logic [3:0] a0, input logic [15:0] d0,
                        input logic v1, input logic [1:0] l1, input logic [3:0] a1, input logic [15:0] d1);
        @(negedge clk);
        req0_valid = v0; req0_l_s = l0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_l_s = l1; req1_addr = a1; req1_wdata = d1;
        #2;
        judge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 2'b00, 4'd0, 16'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({req0_ready, req1_ready, resp0_valid, resp1_valid, mem_l_s, mem_addr}),
              64'(0));
        check({name, "_data"}, 64'({resp0_rdata, resp1_rdata, mem_wdata}), 64'(0));
    endtask

    initial begin
        logic [15:0] old5;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'd0;
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        clr = 1'b0;
        #2;
        judge();

        // Contention straight out of reset: port 0 first, then alternate.
        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 4'd1, 16'd0, 1'b1, 2'b10, 4'd2, 16'd0);
        idle(2);

        step(1'b1, 2'b01, 4'd3, 16'hBEEF, 1'b0, 2'b00, 4'd0, 16'd0);
        idle(1);
        step(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, 2'b10, 4'd3, 16'h0000);
        idle(2);

        step(1'b1, 2'b11, 4'd7, 16'h5A5A, 1'b0, 2'b00, 4'd0, 16'd0);
        idle(3);
        check("nop_mem_unchanged", 64'(mem[7]), 64'(ref_mem[7]));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom));
        end
        idle(3);
        for (int i = 0; i < 16; i++) check("mem_contents", 64'(mem[i]), 64'(ref_mem[i]));

        // Reset while a store to address 5 is on the memory bus.
        old5 = ref_mem[5];
        step(1'b1, 2'b01, 4'd5, ~old5, 1'b0, 2'b00, 4'd0, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        accq.delete();
        respq.delete();
        ref_mem[5] = old5;
        lg = 1'b1;
        last_acc = -10;
        #2;
        judge();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_reset_outputs("reset_mid_issue");
        check("reset_no_write", 64'(mem[5]), 64'(old5));
        judge();

        fixed_phase = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 4'd1, 16'd0, 1'b1, 2'b10, 4'd2, 16'd0);
        fixed_phase = 1'b0;
        check("fixed_grants", 64'(fixed_grants), 64'(4));
        idle(4);
        check("drain", 64'({accq.size() != 0, respq.size() != 0}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
